// File: rtl/add_32.sv
// Registered 32-bit adder with carry/overflow/zero flags and one-cycle latency.
// Core is two-level carry lookahead: eight 4-bit CLA groups plus a group lookahead unit.

module add_32_cla4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,
  output logic       gg,
  output logic       gp
);

  // c[i] is the carry into bit i of the group; c[0] is the group carry-in.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
  end

endmodule

module add_32_lookahead (
  input  logic [7:0] g,
  input  logic [7:0] p,
  input  logic       cin,
  output logic [8:0] c
);

  // Each group carry is a flat sum of products over all lower groups, not a ripple.
  always_comb begin
    logic term;
    logic acc;
    c    = '0;
    c[0] = cin;
    for (int unsigned k = 0; k < 8; k++) begin
      acc = cin;
      for (int unsigned m = 0; m <= k; m++) begin
        acc = acc & p[m];
      end
      for (int unsigned j = 0; j <= k; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m <= k; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      c[k+1] = acc;
    end
  end

endmodule

module add_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] sum,
  output logic        carry,
  output logic        ovf,
  output logic        zero,
  output logic        out_valid
);

  logic [31:0] g_bit, p_bit, c_bit, sum_c;
  logic [7:0]  grp_g, grp_p;
  logic [8:0]  grp_c;

  assign g_bit = x & y;
  assign p_bit = x ^ y;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    add_32_cla4 u_cla4 (
      .g   (g_bit[4*gi +: 4]),
      .p   (p_bit[4*gi +: 4]),
      .cin (grp_c[gi]),
      .c   (c_bit[4*gi +: 4]),
      .gg  (grp_g[gi]),
      .gp  (grp_p[gi])
    );
  end

  add_32_lookahead u_lookahead (
    .g   (grp_g),
    .p   (grp_p),
    .cin (1'b0),
    .c   (grp_c)
  );

  assign sum_c = p_bit ^ c_bit;

  logic [31:0] sum_d, sum_q;
  logic        carry_d, carry_q;
  logic        ovf_d, ovf_q;
  logic        zero_d, zero_q;
  logic        out_valid_d, out_valid_q;

  // Data registers hold while idle, so operands are only observed when in_valid is high.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum_c;
      carry_d     = grp_c[8];
      ovf_d       = (x[31] == y[31]) && (sum_c[31] != x[31]);
      zero_d      = (sum_c == '0);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_32.sv
// Directed self-checking bench for add_32, plus a back-to-back pseudo-random stretch.

module tb_add_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] x, y;
  logic [31:0] sum;
  logic        carry, ovf, zero, out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  add_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Flags packed as {carry, ovf, zero, out_valid} in the low nibble.
  task automatic check_res(input string tag, input logic [31:0] e_sum, input logic e_c,
                           input logic e_o, input logic e_z, input logic e_v);
    check({tag, ".sum"}, sum, e_sum);
    check({tag, ".flags"}, {28'h0, carry, ovf, zero, out_valid}, {28'h0, e_c, e_o, e_z, e_v});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    x        = a;
    y        = b;
    in_valid = 1'b1;
    tick();
  endtask

  logic [32:0] ref_r;
  logic [31:0] rx, ry;
  logic        ref_o;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    x        = 32'hffffffff;
    y        = 32'h00000001;
    tick();
    check_res("reset0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_res("reset1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    apply(32'hffffffff, 32'h00000001);
    check_res("ripple", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);
    apply(32'hf0f0f0f0, 32'h0f0f0f0f);
    check_res("compl", 32'hffffffff, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(32'h00020002, 32'h000e000d);
    check_res("small", 32'h0010000f, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(32'h7fffffff, 32'h00000001);
    check_res("povf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(32'h80000000, 32'h80000000);
    check_res("novf", 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1);
    apply(32'h0000ffff, 32'h00000001);
    check_res("grp4", 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(32'h00000000, 32'h00000000);
    check_res("zeros", 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1);
    apply(32'hfffffffe, 32'hffffffff);
    check_res("neg", 32'hfffffffd, 1'b1, 1'b0, 1'b0, 1'b1);

    apply(32'h00000005, 32'h00000003);
    check_res("hold.op", 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    x        = 32'hffffffff;
    y        = 32'h00000001;
    tick();
    check_res("hold.1", 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0);
    x = 32'h80000000;
    y = 32'h80000000;
    tick();
    check_res("hold.2", 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rx    = $urandom;
      ry    = $urandom;
      ref_r = {1'b0, rx} + {1'b0, ry};
      ref_o = (rx[31] == ry[31]) && (ref_r[31] != rx[31]);
      if (i == 200) begin
        rst_n = 1'b0;
        apply(rx, ry);
        check_res("midrst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end else begin
        apply(rx, ry);
        check_res("rand", ref_r[31:0], ref_r[32], ref_o, ref_r[31:0] == 32'h0, 1'b1);
      end
    end

    in_valid = 1'b0;
    tick();
    check("idle.valid", {31'h0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
